// File: rtl/hss_impair_sched.sv
// hss_impair_sched: LFSR-driven skew and link-down impairment scheduler for one HSS lane
module hss_impair_sched #(
  parameter int          DATAWIDTH     = 20,
  parameter int          WORD_SKEW_MOD = 6,
  parameter logic [31:0] LFSR_SEED     = 32'h0000_0001,
  parameter int          GUARD_LEN     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  cfg_mode,
  input  logic [11:0] cfg_period,
  input  logic [15:0] cfg_down_len,
  input  logic [11:0] cfg_down_mask,
  input  logic        force_down,
  input  logic        skew_ack,
  output logic        skew_req,
  output logic [4:0]  bit_skew,
  output logic [3:0]  word_skew,
  output logic        link_down,
  output logic [2:0]  state,
  output logic [15:0] event_cnt,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    DECIDE   = 3'd2,
    SKEW_REQ = 3'd3,
    DOWN     = 3'd4,
    RECOVER  = 3'd5
  } state_t;
  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [4:0]  DW       = 5'(DATAWIDTH);
  localparam logic [3:0]  WM       = 4'(WORD_SKEW_MOD);
  localparam logic [15:0] GUARD_M1 = 16'(GUARD_LEN - 1);
  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [11:0] period_cnt_q, period_cnt_d;
  logic [15:0] down_cnt_q, down_cnt_d;
  logic        pending_q, pending_d;
  logic        skew_req_q, skew_req_d;
  logic        link_down_q, link_down_d;
  logic        busy_q, busy_d;
  logic [4:0]  bit_skew_q, bit_skew_d;
  logic [3:0]  word_skew_q, word_skew_d;
  logic [15:0] event_cnt_q, event_cnt_d;
  logic [4:0]  bit_c;
  logic [3:0]  word_c;
  logic [3:0]  word_raw;
  logic [15:0] down_m1;
  logic        trig;
  logic        force_now;
  logic        ev_inc;
  // Candidates are folded into range with a single subtraction; raw values never exceed twice the modulus.
  assign bit_c     = lfsr_q[4:0] >= DW ? lfsr_q[4:0] - DW : lfsr_q[4:0];
  assign word_raw  = {1'b0, lfsr_q[10:8]};
  assign word_c    = word_raw >= WM ? word_raw - WM : word_raw;
  assign down_m1   = cfg_down_len == 16'd0 ? 16'd0 : cfg_down_len - 16'd1;
  assign trig      = cfg_mode == 2'b11 && (lfsr_q[11:0] & cfg_down_mask) == cfg_down_mask;
  assign force_now = pending_q | force_down;
  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    down_cnt_d   = down_cnt_q;
    pending_d    = pending_q | force_down;
    bit_skew_d   = bit_skew_q;
    word_skew_d  = word_skew_q;
    ev_inc       = 1'b0;
    lfsr_d       = enable ? ({1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0)) : lfsr_q;
    if (!enable) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = RUN;
          period_cnt_d = 12'd0;
        end
        RUN: begin
          if (cfg_period != 12'd0 && period_cnt_q >= cfg_period - 12'd1) state_d = DECIDE;
          else if (cfg_period == 12'd0 && pending_q) state_d = DECIDE;
          else period_cnt_d = period_cnt_q + 12'd1;
        end
        DECIDE: begin
          if (force_now || trig) begin
            state_d    = DOWN;
            pending_d  = 1'b0;
            down_cnt_d = 16'd0;
            ev_inc     = 1'b1;
          end else if (cfg_mode != 2'b00) begin
            state_d     = SKEW_REQ;
            word_skew_d = word_c;
            bit_skew_d  = cfg_mode[1] ? bit_c : bit_skew_q;
            ev_inc      = 1'b1;
          end else begin
            state_d      = RUN;
            period_cnt_d = 12'd0;
          end
        end
        SKEW_REQ: begin
          if (skew_ack) begin
            state_d      = RUN;
            period_cnt_d = 12'd0;
          end
        end
        DOWN: begin
          if (down_cnt_q >= down_m1) begin
            state_d    = RECOVER;
            down_cnt_d = 16'd0;
          end else down_cnt_d = down_cnt_q + 16'd1;
        end
        RECOVER: begin
          if (down_cnt_q >= GUARD_M1) begin
            state_d      = RUN;
            period_cnt_d = 12'd0;
          end else down_cnt_d = down_cnt_q + 16'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    skew_req_d  = state_d == SKEW_REQ;
    link_down_d = state_d == DOWN;
    busy_d      = state_d != IDLE;
    event_cnt_d = ev_inc && event_cnt_q != 16'hFFFF ? event_cnt_q + 16'd1 : event_cnt_q;
  end
  // State and output registers; reset clears an active window or request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      period_cnt_q <= 12'd0;
      down_cnt_q   <= 16'd0;
      pending_q    <= 1'b0;
      skew_req_q   <= 1'b0;
      link_down_q  <= 1'b0;
      busy_q       <= 1'b0;
      bit_skew_q   <= 5'd0;
      word_skew_q  <= 4'd0;
      event_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      period_cnt_q <= period_cnt_d;
      down_cnt_q   <= down_cnt_d;
      pending_q    <= pending_d;
      skew_req_q   <= skew_req_d;
      link_down_q  <= link_down_d;
      busy_q       <= busy_d;
      bit_skew_q   <= bit_skew_d;
      word_skew_q  <= word_skew_d;
      event_cnt_q  <= event_cnt_d;
    end
  end
  assign skew_req  = skew_req_q;
  assign bit_skew  = bit_skew_q;
  assign word_skew = word_skew_q;
  assign link_down = link_down_q;
  assign state     = state_q;
  assign event_cnt = event_cnt_q;
  assign busy      = busy_q;
endmodule

// File: doc/hss_impair_sched.md
# hss_impair_sched

Impairment scheduler for the fake 20-bit HSS lane model in the PCS testbench. It decides when and what the lane injects: new bit/word skew values and link-down windows. Events are driven by a free-running LFSR and a programmable period. The block hands skew values to the lane through a req/ack handshake and drives the lane's link-down gate directly. It sits between the bench configuration and each lane's skew/down inputs, one instance per lane.

## Interface
- DATAWIDTH, 20, lane parallel width; bit_skew range is 0..DATAWIDTH-1
- WORD_SKEW_MOD, 6, word_skew range is 0..WORD_SKEW_MOD-1
- LFSR_SEED, 32'h0000_0001, LFSR reset value; must be nonzero
- GUARD_LEN, 16, cycles of RECOVER after a link-down window
- clk  in  1  lane TXDCLK-domain clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = schedule events, 0 = return to IDLE
- cfg_mode  in  2  00 none, 01 word skew only, 10 bit+word skew, 11 bit+word skew + random link-down
- cfg_period  in  12  RUN cycles between decisions; 0 = never decide
- cfg_down_len  in  16  link-down window length in cycles; 0 treated as 1
- cfg_down_mask  in  12  random down trigger when (lfsr[11:0] & mask) == mask
- force_down  in  1  pulse; sets a sticky pending-down flag
- skew_ack  in  1  lane accepted bit_skew/word_skew
- skew_req  out  1  new skew values valid
- bit_skew  out  5  bit skew for lane
- word_skew  out  4  word skew for lane
- link_down  out  1  lane output forced low while 1
- state  out  3  current FSM state code
- event_cnt  out  16  count of issued events (skew + down), saturating
- busy  out  1  state is not IDLE

## Operation
- LFSR: 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1). Shifts every cycle while enable=1 and holds while enable=0.
- Skew candidates are computed combinationally from the current LFSR:
  - bit_c = lfsr[4:0] >= DATAWIDTH ? lfsr[4:0]-DATAWIDTH : lfsr[4:0]
  - word_c = lfsr[10:8] >= WORD_SKEW_MOD ? lfsr[10:8]-WORD_SKEW_MOD : lfsr[10:8]
- States (codes): IDLE 0, RUN 1, DECIDE 2, SKEW_REQ 3, DOWN 4, RECOVER 5.
- IDLE: enable=1 → RUN with period_cnt=0.
- RUN: period_cnt increments each cycle. When period_cnt == cfg_period-1 (and cfg_period≠0), go to DECIDE. If cfg_period=0, stay in RUN, but a pending force_down still goes to DECIDE.
- DECIDE (one cycle), priority order:
  - force pending, or cfg_mode==11 with the mask trigger → DOWN; clear pending
  - else cfg_mode≠00 → SKEW_REQ and latch outputs: mode 01 sets word_skew=word_c and bit_skew unchanged; modes 10/11 set both
  - else → RUN
- SKEW_REQ: skew_req=1 and values stable. When skew_ack=1 in the same cycle → RUN, and skew_req=0 the next cycle. Waits indefinitely. skew_ack is ignored in every other state.
- DOWN: link_down=1. down_cnt counts to max(cfg_down_len,1)-1, then → RECOVER.
- RECOVER: link_down=0. GUARD_LEN cycles, then → RUN. A force_down arriving here stays pending.
- Event counting: event_cnt increments on entry to SKEW_REQ or DOWN and saturates at 16'hFFFF.
- Disable: enable=0 in any state → IDLE next cycle. skew_req, link_down and the pending flag clear. bit_skew, word_skew and event_cnt hold.
- cfg_* may change at any time. They are sampled live, and a new cfg_period applies from the next compare.

## Timing
- Reset values: state=IDLE, skew_req=0, bit_skew=0, word_skew=0, link_down=0, event_cnt=0, busy=0, lfsr=LFSR_SEED, pending=0.
- All outputs are registered; there is no combinational path from input to output.
- enable sampled high at cycle 0 → RUN at cycle 1.
- First DECIDE is at cycle cfg_period+1.
- skew_req rises at cycle cfg_period+2.
- With skew_ack tied high, each skew event occupies cfg_period+2 cycles: RUN×P, DECIDE×1, SKEW_REQ×1.
- link_down is high for exactly max(cfg_down_len,1) cycles, beginning the cycle after DECIDE. The next DECIDE is no earlier than GUARD_LEN+cfg_period cycles after link_down falls.
- force_down arriving in the same cycle DECIDE samples it takes effect in that decision.
- Reset asserted mid-operation clears everything immediately, including an active link_down or skew_req.

## Test plan
- Reset, then enable=1, cfg_mode=10, cfg_period=8, skew_ack=1 → skew_req pulses at cycles 10, 20, 30. bit_skew is always ≤19 and word_skew always ≤5. event_cnt reaches 3 after cycle 30.
- cfg_mode=01, skew_ack held 0 for 50 cycles, then 1 → skew_req stays high and its values stay stable for all 50 cycles. bit_skew stays 0. A single transfer occurs, and event_cnt increments by 1.
- cfg_mode=00, cfg_period=0, force_down pulse, cfg_down_len=100 → link_down high for exactly 100 cycles, then 16 RECOVER cycles, then RUN. event_cnt=1.
- cfg_mode=11, cfg_down_mask=12'h000, cfg_down_len=0 → every DECIDE goes to DOWN, and link_down is high for exactly 1 cycle each time. No skew_req is ever asserted.
- enable dropped while in DOWN at the 40th cycle → link_down=0 and state=IDLE on the next cycle. bit_skew, word_skew and event_cnt are unchanged.
- Force event_cnt to FFFF via a long run with cfg_period=1 (this takes 196,605 cycles) → event_cnt holds at FFFF with no wrap.
